// File: rtl/inmux_dat_arb.sv
// inmux_dat_arb: round-robin gather of PORTS upstream word sources onto one
// downstream channel through a 2-entry FIFO. Grants depend only on the
// registered FIFO count, so there is no combinational path from i_inmux_ack
// to t_k_ack.
module inmux_dat_arb #(
  parameter int SLICES     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PORTS      = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [PORTS*SLICES*DATA_WIDTH-1:0] t_k_dat,
  input  logic [PORTS-1:0]                   t_k_req,
  output logic [PORTS-1:0]                   t_k_ack,
  output logic [SLICES*DATA_WIDTH-1:0]       i_inmux_dat,
  output logic                               i_inmux_req,
  input  logic                               i_inmux_ack,
  output logic [SEL_WIDTH-1:0]               sel
);

  localparam int W = SLICES * DATA_WIDTH;

  logic [W-1:0]         mem_dat_q [2];
  logic [SEL_WIDTH-1:0] mem_sel_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [SEL_WIDTH-1:0] last_q;
  logic [W-1:0]         dat_q, dat_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;

  logic                 space;
  logic                 found;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic [SEL_WIDTH-1:0] cand_idx;
  logic                 push, pop;
  logic [W-1:0]         push_dat;

  assign space       = (count_q < 2'd2);
  assign i_inmux_req = (count_q != 2'd0);
  assign i_inmux_dat = dat_q;
  assign sel         = sel_q;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      cand_idx = SEL_WIDTH'((32'(last_q) + i) % PORTS);
      if (!found && t_k_req[cand_idx]) begin
        found   = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  // One-hot grant, only while the FIFO has a free slot.
  always_comb begin
    t_k_ack = '0;
    if (space && found) t_k_ack[gnt_idx] = 1'b1;
  end

  assign push     = space & found;
  assign pop      = i_inmux_req & i_inmux_ack;
  assign push_dat = t_k_dat[gnt_idx*W +: W];

  // Next pointers, occupancy and the head word that will be presented.
  // The head is registered: on push-into-head-slot it bypasses the memory,
  // and when the FIFO drains it holds the last popped word.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    dat_d = dat_q;
    sel_d = sel_q;
    if (count_d != 2'd0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        dat_d = push_dat;
        sel_d = gnt_idx;
      end else begin
        dat_d = mem_dat_q[rd_ptr_d];
        sel_d = mem_sel_q[rd_ptr_d];
      end
    end
  end

  // FIFO storage, pointers, priority pointer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_dat_q[0] <= '0;
      mem_dat_q[1] <= '0;
      mem_sel_q[0] <= '0;
      mem_sel_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      last_q       <= SEL_WIDTH'(PORTS - 1);
      dat_q        <= '0;
      sel_q        <= '0;
    end else begin
      if (push) begin
        mem_dat_q[wr_ptr_q] <= push_dat;
        mem_sel_q[wr_ptr_q] <= gnt_idx;
        last_q              <= gnt_idx;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: tb/tb_inmux_dat_arb.sv
// Directed bench for inmux_dat_arb: inputs change 1 time unit after the rising
// edge, outputs are checked on the falling edge.
module tb_inmux_dat_arb;

  localparam int W = 128;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [4*W-1:0] t_k_dat;
  logic [3:0]     t_k_req;
  logic [3:0]     t_k_ack;
  logic [W-1:0]   i_inmux_dat;
  logic           i_inmux_req;
  logic           i_inmux_ack;
  logic [1:0]     sel;

  logic [W-1:0]   wd [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inmux_dat_arb #(
    .SLICES(4), .DATA_WIDTH(32), .PORTS(4), .SEL_WIDTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .t_k_dat(t_k_dat), .t_k_req(t_k_req),
    .t_k_ack(t_k_ack), .i_inmux_dat(i_inmux_dat), .i_inmux_req(i_inmux_req),
    .i_inmux_ack(i_inmux_ack), .sel(sel)
  );

  always_comb t_k_dat = {wd[3], wd[2], wd[1], wd[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    t_k_req     = '0;
    i_inmux_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (i_inmux_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", i_inmux_req); end
    checks++;
    if (i_inmux_dat !== '0) begin errors++; $display("FAIL reset_dat got %h exp 0", i_inmux_dat); end
    checks++;
    if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
    checks++;
    if (t_k_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", t_k_ack); end
    tick();
  endtask

  task automatic test_single_port();
    do_reset();
    wd[2] = {4{32'hA5A5A5A5}};
    t_k_req = 4'b0100;
    i_inmux_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (t_k_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b exp 0100", t_k_ack); end
    checks++;
    if (i_inmux_req !== 1'b0) begin errors++; $display("FAIL single_req0 got %b exp 0", i_inmux_req); end
    tick();
    @(negedge clk);
    checks++;
    if (i_inmux_req !== 1'b1) begin errors++; $display("FAIL single_req1 got %b exp 1", i_inmux_req); end
    checks++;
    if (sel !== 2'd2) begin errors++; $display("FAIL single_sel got %0d exp 2", sel); end
    checks++;
    if (i_inmux_dat !== {4{32'hA5A5A5A5}}) begin errors++; $display("FAIL single_dat got %h exp %h", i_inmux_dat, {4{32'hA5A5A5A5}}); end
    tick();
    t_k_req = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int p = 0; p < 4; p++) wd[p] = {4{32'hC0DE0000 | 32'(p)}};
    t_k_req = 4'b1111;
    i_inmux_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (t_k_ack !== 4'(1 << (k % 4))) begin errors++; $display("FAIL b2b_ack[%0d] got %b exp %b", k, t_k_ack, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++;
        if (i_inmux_req !== 1'b1) begin errors++; $display("FAIL b2b_req[%0d] got %b exp 1", k, i_inmux_req); end
        checks++;
        if (sel !== 2'((k - 1) % 4)) begin errors++; $display("FAIL b2b_sel[%0d] got %0d exp %0d", k, sel, (k - 1) % 4); end
        checks++;
        if (i_inmux_dat !== wd[(k - 1) % 4]) begin errors++; $display("FAIL b2b_dat[%0d] got %h exp %h", k, i_inmux_dat, wd[(k - 1) % 4]); end
      end
      tick();
    end
    t_k_req = '0;
    i_inmux_ack = 1'b0;
  endtask

  // Fill the FIFO with no consumer, then release one slot (continues into full case).
  task automatic test_fill_and_full();
    do_reset();
    wd[0] = {4{32'h00000F00}};
    wd[1] = {4{32'h11111F11}};
    t_k_req = 4'b0011;
    i_inmux_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (t_k_ack !== 4'b0001) begin errors++; $display("FAIL fill_ack0 got %b exp 0001", t_k_ack); end
    tick();
    @(negedge clk);
    checks++;
    if (t_k_ack !== 4'b0010) begin errors++; $display("FAIL fill_ack1 got %b exp 0010", t_k_ack); end
    tick();
    @(negedge clk);
    checks++;
    if (t_k_ack !== 4'b0000) begin errors++; $display("FAIL fill_ack2 got %b exp 0000", t_k_ack); end
    checks++;
    if (sel !== 2'd0 || i_inmux_dat !== wd[0]) begin errors++; $display("FAIL fill_head got sel %0d dat %h exp sel 0 dat %h", sel, i_inmux_dat, wd[0]); end
    tick();
    @(negedge clk);
    checks++;
    if (t_k_ack !== 4'b0000) begin errors++; $display("FAIL fill_ack3 got %b exp 0000", t_k_ack); end
    // Full: consumer takes one word; grant must still be withheld this cycle.
    i_inmux_ack = 1'b1;
    #1;
    checks++;
    if (t_k_ack !== 4'b0000) begin errors++; $display("FAIL full_ack got %b exp 0000", t_k_ack); end
    tick();
    i_inmux_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (sel !== 2'd1 || i_inmux_dat !== wd[1]) begin errors++; $display("FAIL full_head got sel %0d dat %h exp sel 1 dat %h", sel, i_inmux_dat, wd[1]); end
    checks++;
    if (t_k_ack !== 4'b0001) begin errors++; $display("FAIL full_regrant got %b exp 0001", t_k_ack); end
    tick();
    @(negedge clk);
    checks++;
    if (t_k_ack !== 4'b0000) begin errors++; $display("FAIL full_again got %b exp 0000", t_k_ack); end
    tick();
    t_k_req = '0;
  endtask

  task automatic test_push_pop();
    do_reset();
    wd[3] = {4{32'h33333333}};
    wd[1] = {4{32'h1234ABCD}};
    t_k_req = 4'b1000;
    i_inmux_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (t_k_ack !== 4'b1000) begin errors++; $display("FAIL pp_ack0 got %b exp 1000", t_k_ack); end
    tick();
    t_k_req = 4'b0010;
    i_inmux_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (sel !== 2'd3 || i_inmux_dat !== wd[3] || i_inmux_req !== 1'b1) begin errors++; $display("FAIL pp_head0 got req %b sel %0d dat %h exp req 1 sel 3 dat %h", i_inmux_req, sel, i_inmux_dat, wd[3]); end
    checks++;
    if (t_k_ack !== 4'b0010) begin errors++; $display("FAIL pp_ack1 got %b exp 0010", t_k_ack); end
    tick();
    t_k_req = '0;
    i_inmux_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (sel !== 2'd1 || i_inmux_dat !== wd[1] || i_inmux_req !== 1'b1) begin errors++; $display("FAIL pp_head1 got req %b sel %0d dat %h exp req 1 sel 1 dat %h", i_inmux_req, sel, i_inmux_dat, wd[1]); end
    i_inmux_ack = 1'b1;
    tick();
    i_inmux_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (i_inmux_req !== 1'b0) begin errors++; $display("FAIL pp_empty got %b exp 0", i_inmux_req); end
    checks++;
    if (sel !== 2'd1 || i_inmux_dat !== wd[1]) begin errors++; $display("FAIL pp_hold got sel %0d dat %h exp sel 1 dat %h", sel, i_inmux_dat, wd[1]); end
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    wd[0] = {4{32'hDEAD0000}};
    wd[1] = {4{32'hBEEF0001}};
    wd[2] = {4{32'h0BAD0002}};
    wd[3] = {4{32'hF00D0003}};
    t_k_req = 4'b0011;
    i_inmux_ack = 1'b0;
    tick();
    tick();
    t_k_req = 4'b1111;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (i_inmux_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b exp 0", i_inmux_req); end
    checks++;
    if (i_inmux_dat !== '0) begin errors++; $display("FAIL rst_mid_dat got %h exp 0", i_inmux_dat); end
    checks++;
    if (sel !== 2'd0) begin errors++; $display("FAIL rst_mid_sel got %0d exp 0", sel); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (t_k_ack !== 4'b0001) begin errors++; $display("FAIL rst_mid_grant got %b exp 0001", t_k_ack); end
    tick();
    @(negedge clk);
    checks++;
    if (i_inmux_req !== 1'b1 || sel !== 2'd0 || i_inmux_dat !== wd[0]) begin errors++; $display("FAIL rst_mid_head got req %b sel %0d dat %h exp req 1 sel 0 dat %h", i_inmux_req, sel, i_inmux_dat, wd[0]); end
    checks++;
    if (t_k_ack !== 4'b0010) begin errors++; $display("FAIL rst_mid_grant2 got %b exp 0010", t_k_ack); end
    tick();
    t_k_req = '0;
  endtask

  initial begin
    for (int p = 0; p < 4; p++) wd[p] = '0;
    reset_n     = 1'b0;
    t_k_req     = '0;
    i_inmux_ack = 1'b0;
    test_reset();
    test_single_port();
    test_back_to_back();
    test_fill_and_full();
    test_push_pop();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
